// File: rtl/timer.sv
// MM:SS free-running clock: a prescaler divides clk down to a one-second tick,
// and four cascaded BCD digit registers count 00:00..59:59 and wrap.
module timer #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] sec_units,
    output logic [2:0] sec_tens,
    output logic [3:0] min_units,
    output logic [2:0] min_tens
);

    localparam int PCNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(TICKS_PER_SEC - 1);

    logic [PCNT_W-1:0] pcnt_r;
    logic [PCNT_W-1:0] pcnt_nxt_s;
    logic              tick_s;

    logic [3:0] sec_units_r, sec_units_nxt_s;
    logic [2:0] sec_tens_r,  sec_tens_nxt_s;
    logic [3:0] min_units_r, min_units_nxt_s;
    logic [2:0] min_tens_r,  min_tens_nxt_s;
    logic       sec_units_carry_s;
    logic       sec_tens_carry_s;
    logic       min_units_carry_s;

    // Prescaler: one tick every TICKS_PER_SEC edges, restarting from zero.
    always_comb begin
        pcnt_nxt_s = pcnt_r;
        tick_s     = 1'b0;
        if (pcnt_r == PCNT_MAX) begin
            pcnt_nxt_s = {PCNT_W{1'b0}};
            tick_s     = 1'b1;
        end else begin
            pcnt_nxt_s = pcnt_r + PCNT_W'(1'b1);
            tick_s     = 1'b0;
        end
    end

    // Digit cascade; >= comparisons also pull any illegal code back to zero.
    always_comb begin
        sec_units_nxt_s   = sec_units_r;
        sec_tens_nxt_s    = sec_tens_r;
        min_units_nxt_s   = min_units_r;
        min_tens_nxt_s    = min_tens_r;
        sec_units_carry_s = 1'b0;
        sec_tens_carry_s  = 1'b0;
        min_units_carry_s = 1'b0;

        if (tick_s) begin
            if (sec_units_r >= 4'd9) begin
                sec_units_nxt_s   = 4'd0;
                sec_units_carry_s = 1'b1;
            end else begin
                sec_units_nxt_s   = sec_units_r + 4'd1;
            end
        end else begin
            sec_units_nxt_s = sec_units_r;
        end

        if (sec_units_carry_s) begin
            if (sec_tens_r >= 3'd5) begin
                sec_tens_nxt_s   = 3'd0;
                sec_tens_carry_s = 1'b1;
            end else begin
                sec_tens_nxt_s   = sec_tens_r + 3'd1;
            end
        end else begin
            sec_tens_nxt_s = sec_tens_r;
        end

        if (sec_tens_carry_s) begin
            if (min_units_r >= 4'd9) begin
                min_units_nxt_s   = 4'd0;
                min_units_carry_s = 1'b1;
            end else begin
                min_units_nxt_s   = min_units_r + 4'd1;
            end
        end else begin
            min_units_nxt_s = min_units_r;
        end

        // The carry out of the minutes tens digit is dropped: 59:59 wraps to 00:00.
        if (min_units_carry_s) begin
            if (min_tens_r >= 3'd5) begin
                min_tens_nxt_s = 3'd0;
            end else begin
                min_tens_nxt_s = min_tens_r + 3'd1;
            end
        end else begin
            min_tens_nxt_s = min_tens_r;
        end
    end

    // State registers with synchronous active-low reset to 00:00.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt_r      <= {PCNT_W{1'b0}};
            sec_units_r <= 4'd0;
            sec_tens_r  <= 3'd0;
            min_units_r <= 4'd0;
            min_tens_r  <= 3'd0;
        end else begin
            pcnt_r      <= pcnt_nxt_s;
            sec_units_r <= sec_units_nxt_s;
            sec_tens_r  <= sec_tens_nxt_s;
            min_units_r <= min_units_nxt_s;
            min_tens_r  <= min_tens_nxt_s;
        end
    end

    assign sec_units = sec_units_r;
    assign sec_tens  = sec_tens_r;
    assign min_units = min_units_r;
    assign min_tens  = min_tens_r;

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: one instance with TICKS_PER_SEC=1, one with 4,
// checked at the falling edge against hand-computed MM:SS values.
module tb_timer;

    logic clk;
    logic reset_a;
    logic reset_b;

    logic [3:0] a_su, b_su;
    logic [2:0] a_st, b_st;
    logic [3:0] a_mu, b_mu;
    logic [2:0] a_mt, b_mt;

    logic [13:0] obs_a;
    logic [13:0] obs_b;

    int checks = 0;
    int errors = 0;

    timer #(.TICKS_PER_SEC(1)) dut_a (
        .clk       (clk),
        .reset     (reset_a),
        .sec_units (a_su),
        .sec_tens  (a_st),
        .min_units (a_mu),
        .min_tens  (a_mt)
    );

    timer #(.TICKS_PER_SEC(4)) dut_b (
        .clk       (clk),
        .reset     (reset_b),
        .sec_units (b_su),
        .sec_tens  (b_st),
        .min_units (b_mu),
        .min_tens  (b_mt)
    );

    assign obs_a = {a_mt, a_mu, a_st, a_su};
    assign obs_b = {b_mt, b_mu, b_st, b_su};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare a packed {mt,mu,st,su} observation against MM:SS.
    task automatic check(input string tag, input logic [13:0] obs, input int mm, input int ss);
        logic [13:0] exp;
        exp = {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d%0d:%0d%0d expected %0d%0d:%0d%0d", tag,
                   obs[13:11], obs[10:7], obs[6:4], obs[3:0],
                   exp[13:11], exp[10:7], exp[6:4], exp[3:0]);
        end
    endtask

    // Every digit of instance A must stay inside its BCD range.
    task automatic range_check();
        logic in_range;
        in_range = (a_mt <= 3'd5) && (a_st <= 3'd5) && (a_mu <= 4'd9) && (a_su <= 4'd9);
        checks++;
        assert (in_range === 1'b1) else begin
            errors++;
            $error("FAIL range: observed %0d%0d:%0d%0d expected digits within 5,9,5,9",
                   a_mt, a_mu, a_st, a_su);
        end
    endtask

    // Advance n edges on instance A, range-checking after each.
    task automatic walk_a(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            range_check();
        end
    endtask

    initial begin
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);

        // Reset hold for three edges on both instances
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("a_reset_hold", obs_a, 0, 0);
            check("b_reset_hold", obs_b, 0, 0);
        end

        // TICKS_PER_SEC=1: walk through every carry boundary
        reset_a = 1'b1;
        walk_a(1);    check("a_k1",    obs_a, 0, 1);
        walk_a(8);    check("a_k9",    obs_a, 0, 9);
        walk_a(1);    check("a_k10",   obs_a, 0, 10);
        walk_a(49);   check("a_k59",   obs_a, 0, 59);
        walk_a(1);    check("a_k60",   obs_a, 1, 0);
        walk_a(539);  check("a_k599",  obs_a, 9, 59);
        walk_a(1);    check("a_k600",  obs_a, 10, 0);
        walk_a(2999); check("a_k3599", obs_a, 59, 59);
        walk_a(1);    check("a_k3600", obs_a, 0, 0);
        walk_a(1);    check("a_k3601", obs_a, 0, 1);
        check("b_held_in_reset", obs_b, 0, 0);

        // Reset mid-count from 12:34
        walk_a(753);  check("a_1234",  obs_a, 12, 34);
        reset_a = 1'b0;
        @(negedge clk); check("a_mid_reset",     obs_a, 0, 0);
        @(negedge clk); check("a_mid_reset_hold", obs_a, 0, 0);
        reset_a = 1'b1;
        @(negedge clk); check("a_after_release", obs_a, 0, 1);

        // TICKS_PER_SEC=4: first advance on the fourth edge
        reset_b = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("b_pre_tick", obs_b, 0, 0);
        end
        @(negedge clk); check("b_edge4", obs_b, 0, 1);
        repeat (35) @(negedge clk);
        check("b_edge39", obs_b, 0, 9);
        @(negedge clk); check("b_edge40", obs_b, 0, 10);

        // Fresh start, then reset on edge 6 with pcnt mid-second
        reset_b = 1'b0;
        @(negedge clk); check("b_reset2", obs_b, 0, 0);
        reset_b = 1'b1;
        repeat (5) @(negedge clk);
        check("b_edge5", obs_b, 0, 1);
        reset_b = 1'b0;
        @(negedge clk); check("b_reset_edge6", obs_b, 0, 0);
        reset_b = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("b_no_carryover", obs_b, 0, 0);
        end
        @(negedge clk); check("b_release_edge4", obs_b, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
